uart_cmd_sequencer: RTL

Command-level controller on the output side of the UART byte receiver. It acknowledges each received byte and assembles two-byte frames (command byte, then address byte). It validates the address and presents each frame to the sensor-control logic through a valid/ready handshake. Protocol faults are reported as one-cycle error pulses: bad address, inter-byte timeout and overrun.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_sequencer_rdy_edge_detect.sv | 28 ++
 rtl/uart_cmd_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, error codes and address check for the UART command sequencer.
package uart_cmd_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_ADDR = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  localparam int unsigned ADDR_COUNT_DEFAULT = 32'd32;

  function automatic logic addr_legal(input logic [7:0] addr, input int unsigned count);
    return ({24'd0, addr} < count);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_rdy_edge_detect.sv
// Rising-edge detector on the receiver ready flag; emits the byte-event pulse
// and the acknowledge pulse one cycle later.
module rdy_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx_rdy,
  output logic o_byte_evt,
  output logic o_rx_rdy_clr
);

  logic r_rdy_q;
  logic r_clr;

  assign o_byte_evt   = i_rx_rdy & ~r_rdy_q;
  assign o_rx_rdy_clr = r_clr;

  // Previous ready level and delayed acknowledge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdy_q <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_rdy_q <= i_rx_rdy;
      r_clr   <= o_byte_evt;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles command/address byte pairs into frames with valid/ready hand-off.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_COUNT     = ADDR_COUNT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 32'd5_000_000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_addr,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy
);

  logic       w_byte_evt;
  logic       w_to_hit;
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_cmd_code;
  logic [7:0] w_code_nxt;
  logic [7:0] r_cmd_addr;
  logic [7:0] w_addr_nxt;
  logic       r_cmd_valid;
  logic       r_err_valid;
  logic       w_err_nxt;
  logic [1:0] r_err_code;
  logic [1:0] w_err_code_nxt;
  logic       r_busy;

  rdy_edge_detect u_edge (
    .i_clk        (clk_50m),
    .i_rst_n      (rst_n),
    .i_rx_rdy     (rx_rdy),
    .o_byte_evt   (w_byte_evt),
    .o_rx_rdy_clr (rx_rdy_clr)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYCLES - 32'd1);
  logic [22:0] r_to_cnt;

  // Saturating wait counter, held at zero outside WAIT_ADDR
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_to_cnt <= 23'd0;
    end else if (r_state != ST_WAIT_ADDR) begin
      r_to_cnt <= 23'd0;
    end else if (r_to_cnt != 23'h7F_FFFF) begin
      r_to_cnt <= r_to_cnt + 23'd1;
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_ADDR) && (r_to_cnt == TO_LAST);
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_to_hit         = 1'b0;
`endif

  // Next-state and latch decode; a byte always beats a same-cycle timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_code_nxt     = r_cmd_code;
    w_addr_nxt     = r_cmd_addr;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (w_byte_evt) begin
          w_code_nxt  = rx_data;
          w_state_nxt = ST_WAIT_ADDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_ADDR: begin
        if (w_byte_evt && addr_legal(rx_data, ADDR_COUNT)) begin
          w_addr_nxt  = rx_data;
          w_state_nxt = ST_HOLD;
        end else if (w_byte_evt) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_BAD_ADDR;
          w_state_nxt    = ST_IDLE;
        end else if (w_to_hit) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_ADDR;
        end
      end
      ST_HOLD: begin
        if (cmd_ready && w_byte_evt) begin
          w_code_nxt  = rx_data;
          w_state_nxt = ST_WAIT_ADDR;
        end else if (cmd_ready) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_evt) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_OVERRUN;
          w_state_nxt    = ST_HOLD;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, frame latches and registered status outputs
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_code  <= 8'd0;
      r_cmd_addr  <= 8'd0;
      r_cmd_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_code  <= w_code_nxt;
      r_cmd_addr  <= w_addr_nxt;
      r_cmd_valid <= (w_state_nxt == ST_HOLD);
      r_err_valid <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_addr  = r_cmd_addr;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign busy      = r_busy;

endmodule
